// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS main control FSM:
// opcode/funct encodings, ALUOp codes, FSM state encoding and
// datapath mux-select codes.
package mips_ctrl_pkg;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Funct (IR[5:0])
    localparam logic [5:0] FN_JR    = 6'b001000;

    // ALUOp codes consumed by the ALU control decoder
    localparam logic [2:0] ALU_R    = 3'b111;
    localparam logic [2:0] ALU_ADDI = 3'b110;
    localparam logic [2:0] ALU_ORI  = 3'b101;
    localparam logic [2:0] ALU_ANDI = 3'b011;
    localparam logic [2:0] ALU_LUI  = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b100;

    // Mux selects
    localparam logic [1:0] REGDST_RT   = 2'b00;
    localparam logic [1:0] REGDST_RD   = 2'b01;
    localparam logic [1:0] REGDST_RA   = 2'b10;
    localparam logic [1:0] M2R_ALUOUT  = 2'b00;
    localparam logic [1:0] M2R_MDR     = 2'b01;
    localparam logic [1:0] M2R_PC      = 2'b10;
    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;
    localparam logic [1:0] PCSRC_ALU   = 2'b00;
    localparam logic [1:0] PCSRC_OUT   = 2'b01;
    localparam logic [1:0] PCSRC_JUMP  = 2'b10;
    localparam logic [1:0] PCSRC_RS    = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_ALU   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_HALT     = 4'd14
    } state_t;

    function automatic logic is_itype(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ORI) || (op == OP_ANDI) || (op == OP_LUI);
    endfunction

endpackage

// File: rtl/aluop_decoder.sv
// Maps the latched opcode of an immediate ALU instruction to its ALUOp.
// Ports:
//   op      in  6  latched opcode (op_q)
//   alu_op  out 3  ALUOp for EXEC_I; plain add for anything else
module aluop_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op,
    output logic [2:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (op)
            OP_ADDI: alu_op = ALU_ADDI;
            OP_ORI:  alu_op = ALU_ORI;
            OP_ANDI: alu_op = ALU_ANDI;
            OP_LUI:  alu_op = ALU_LUI;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS main control FSM. Sequences fetch/decode/execute/
// memory/writeback over a shared ALU and memory, stalling on mem_ready.
// Ports:
//   clk, reset (async, active-high)
//   opcode, funct, zero, mem_ready         : IR fields, ALU flag, memory handshake
//   pc_write, i_or_d, mem_read, mem_write,
//   ir_write, reg_dst, mem_to_reg,
//   reg_write, alu_src_a, alu_src_b,
//   alu_op, pc_source                      : datapath controls
//   halted                                 : FSM sits in HALT
//   instr_count                            : retired-instruction counter
module multicycle_control_fsm
    import mips_ctrl_pkg::*;
#(
    parameter bit ILLEGAL_HALT = 1'b1,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           opcode,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 i_or_d,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic [1:0]           reg_dst,
    output logic [1:0]           mem_to_reg,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [2:0]           alu_op,
    output logic [1:0]           pc_source,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] instr_count
);

    state_t                 state_reg, state_next;
    // Only the opcode is needed after DECODE: the funct field is consumed
    // entirely by the DECODE-time JR/EXEC_R split.
    logic [5:0]             op_q_reg;
    logic [CNT_WIDTH-1:0]   count_reg;
    logic [2:0]             imm_alu_op;
    logic                   retire;

    aluop_decoder u_aluop_decoder (
        .op     (op_q_reg),
        .alu_op (imm_alu_op)
    );

    // A retire is any entry into FETCH except the first one out of IDLE;
    // a FETCH that merely holds for mem_ready is not an entry.
    assign retire = (state_next == S_FETCH) && (state_reg != S_IDLE) && (state_reg != S_FETCH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            op_q_reg  <= 6'd0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE)
                op_q_reg <= opcode;
            if (retire)
                count_reg <= count_reg + CNT_WIDTH'(1);
        end
    end

    assign instr_count = count_reg;

    always_comb begin
        state_next = state_reg;
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = REGDST_RT;
        mem_to_reg = M2R_ALUOUT;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = 3'b000;
        pc_source  = PCSRC_ALU;
        halted     = 1'b0;

        case (state_reg)
            S_IDLE: state_next = S_FETCH;

            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready)
                    state_next = S_DECODE;
            end

            S_DECODE: begin
                alu_src_b = SRCB_IMM_SH;
                alu_op    = ALU_ADD;
                if (opcode == OP_RTYPE)
                    state_next = (funct == FN_JR) ? S_JR : S_EXEC_R;
                else if (is_itype(opcode))
                    state_next = S_EXEC_I;
                else if (opcode == OP_LW || opcode == OP_SW)
                    state_next = S_MEM_ADDR;
                else if (opcode == OP_BEQ || opcode == OP_BNE)
                    state_next = S_BRANCH;
                else if (opcode == OP_J)
                    state_next = S_JUMP;
                else if (opcode == OP_JAL)
                    state_next = S_JAL;
                else
                    state_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
            end

            S_EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_RT;
                alu_op     = ALU_R;
                state_next = S_WB_ALU;
            end

            S_EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = imm_alu_op;
                state_next = S_WB_ALU;
            end

            S_WB_ALU: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_ALUOUT;
                reg_dst    = (op_q_reg == OP_RTYPE) ? REGDST_RD : REGDST_RT;
                state_next = S_FETCH;
            end

            S_MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALU_ADD;
                state_next = (op_q_reg == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end

            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready)
                    state_next = S_WB_MEM;
            end

            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                reg_dst    = REGDST_RT;
                state_next = S_FETCH;
            end

            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready)
                    state_next = S_FETCH;
            end

            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRCB_RT;
                alu_op     = ALU_SUB;
                pc_source  = PCSRC_OUT;
                pc_write   = (op_q_reg == OP_BEQ) ? zero : ~zero;
                state_next = S_FETCH;
            end

            S_JUMP: begin
                pc_source  = PCSRC_JUMP;
                pc_write   = 1'b1;
                state_next = S_FETCH;
            end

            S_JAL: begin
                pc_source  = PCSRC_JUMP;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = REGDST_RA;
                mem_to_reg = M2R_PC;
                state_next = S_FETCH;
            end

            S_JR: begin
                alu_op     = ALU_R;
                pc_source  = PCSRC_RS;
                pc_write   = 1'b1;
                state_next = S_FETCH;
            end

            S_HALT: begin
                halted     = 1'b1;
                state_next = S_HALT;
            end

            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, i_or_d, mem_read, mem_write, ir_write;
    logic [1:0]  reg_dst, mem_to_reg, alu_src_b, pc_source;
    logic        reg_write, alu_src_a, halted;
    logic [2:0]  alu_op;
    logic [31:0] instr_count;

    int n_asrt = 0;
    int n_fail = 0;

    multicycle_control_fsm #(.ILLEGAL_HALT(1'b1), .CNT_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .halted(halted), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    logic [18:0] obs;
    assign obs = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                  reg_write, alu_src_a, alu_src_b, alu_op, pc_source, halted};

    function automatic logic [18:0] ev(
        input logic pcw, input logic iord, input logic mr, input logic mw, input logic irw,
        input logic [1:0] rd, input logic [1:0] mtr, input logic rw, input logic asa,
        input logic [1:0] asb, input logic [2:0] aop, input logic [1:0] ps, input logic h);
        return {pcw, iord, mr, mw, irw, rd, mtr, rw, asa, asb, aop, ps, h};
    endfunction

    task automatic chk(input string tag, input logic [18:0] exp_v);
        n_asrt++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
        $display("t=%0t %s outs=%h cnt=%0d", $time, tag, obs, instr_count);
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] exp_c);
        n_asrt++;
        assert (instr_count === exp_c)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, instr_count, exp_c);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [18:0] fetch_rdy, fetch_stall, dec, zero_v;

    initial begin
        fetch_rdy   = ev(1,0,1,0,1,2'b00,2'b00,0,0,2'b01,3'b010,2'b00,0);
        fetch_stall = ev(0,0,1,0,0,2'b00,2'b00,0,0,2'b01,3'b010,2'b00,0);
        dec         = ev(0,0,0,0,0,2'b00,2'b00,0,0,2'b11,3'b010,2'b00,0);
        zero_v      = '0;

        // Reset / IDLE
        #12;
        chk("reset_idle", zero_v);
        chk_cnt("reset_cnt", 32'd0);
        reset = 1'b0;
        mem_ready = 1'b1;
        opcode = 6'b000000; funct = 6'b100000;   // ADD

        // ADD
        tick(); chk("add_fetch", fetch_rdy);
        chk_cnt("add_cnt0", 32'd0);
        tick(); chk("add_decode", dec);
        tick(); opcode = 6'b111111; funct = 6'b001000;   // IR change after DECODE ignored
        chk("add_exec_r", ev(0,0,0,0,0,2'b00,2'b00,0,1,2'b00,3'b111,2'b00,0));
        tick(); chk("add_wb", ev(0,0,0,0,0,2'b01,2'b00,1,0,2'b00,3'b000,2'b00,0));
        tick(); chk("add_refetch", fetch_rdy);
        chk_cnt("add_cnt1", 32'd1);

        // LW with 3-cycle memory stall
        opcode = 6'b100011;
        tick(); chk("lw_decode", dec);
        tick(); mem_ready = 1'b0;
        chk("lw_mem_addr", ev(0,0,0,0,0,2'b00,2'b00,0,1,2'b10,3'b010,2'b00,0));
        tick(); chk("lw_mem_rd", ev(0,1,1,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,0));
        for (int i = 0; i < 3; i++) begin
            tick(); chk("lw_mem_rd_hold", ev(0,1,1,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,0));
        end
        mem_ready = 1'b1;
        tick(); chk("lw_wb_mem", ev(0,0,0,0,0,2'b00,2'b01,1,0,2'b00,3'b000,2'b00,0));
        tick(); chk("lw_refetch", fetch_rdy);
        chk_cnt("lw_cnt2", 32'd2);

        // FETCH stall: strobes drop, no retire while holding
        mem_ready = 1'b0; #1;
        chk("fetch_stall", fetch_stall);
        tick(); chk("fetch_stall_hold", fetch_stall);
        chk_cnt("stall_cnt2", 32'd2);
        mem_ready = 1'b1; #1;

        // BEQ, zero=1 -> taken
        opcode = 6'b000100; zero = 1'b1;
        tick(); chk("beq_decode", dec);
        tick(); chk("beq_branch", ev(1,0,0,0,0,2'b00,2'b00,0,1,2'b00,3'b100,2'b01,0));
        tick(); chk("beq_refetch", fetch_rdy);
        chk_cnt("beq_cnt3", 32'd3);

        // BNE, zero=1 -> not taken; zero=0 -> taken (same state)
        opcode = 6'b000101;
        tick(); chk("bne_decode", dec);
        tick(); chk("bne_branch_z1", ev(0,0,0,0,0,2'b00,2'b00,0,1,2'b00,3'b100,2'b01,0));
        zero = 1'b0; #1;
        chk("bne_branch_z0", ev(1,0,0,0,0,2'b00,2'b00,0,1,2'b00,3'b100,2'b01,0));
        tick(); chk("bne_refetch", fetch_rdy);
        chk_cnt("bne_cnt4", 32'd4);

        // JAL
        opcode = 6'b000011;
        tick(); chk("jal_decode", dec);
        tick(); chk("jal_exec", ev(1,0,0,0,0,2'b10,2'b10,1,0,2'b00,3'b000,2'b10,0));
        tick(); chk("jal_refetch", fetch_rdy);
        chk_cnt("jal_cnt5", 32'd5);

        // ORI
        opcode = 6'b001101;
        tick(); chk("ori_decode", dec);
        tick(); chk("ori_exec_i", ev(0,0,0,0,0,2'b00,2'b00,0,1,2'b10,3'b101,2'b00,0));
        tick(); chk("ori_wb", ev(0,0,0,0,0,2'b00,2'b00,1,0,2'b00,3'b000,2'b00,0));
        tick(); chk("ori_refetch", fetch_rdy);
        chk_cnt("ori_cnt6", 32'd6);

        // JR
        opcode = 6'b000000; funct = 6'b001000;
        tick(); chk("jr_decode", dec);
        tick(); chk("jr_exec", ev(1,0,0,0,0,2'b00,2'b00,0,0,2'b00,3'b111,2'b11,0));
        tick(); chk("jr_refetch", fetch_rdy);
        chk_cnt("jr_cnt7", 32'd7);

        // SW interrupted by asynchronous reset in MEM_WR
        opcode = 6'b101011;
        tick(); chk("sw_decode", dec);
        tick(); mem_ready = 1'b0;
        chk("sw_mem_addr", ev(0,0,0,0,0,2'b00,2'b00,0,1,2'b10,3'b010,2'b00,0));
        tick(); chk("sw_mem_wr", ev(0,1,0,1,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,0));
        #2 reset = 1'b1;
        #1 chk("sw_async_reset", zero_v);
        chk_cnt("sw_reset_cnt0", 32'd0);
        #4 reset = 1'b0; mem_ready = 1'b1;
        tick(); chk("post_reset_fetch", fetch_rdy);
        chk_cnt("post_reset_cnt0", 32'd0);

        // Illegal opcode -> HALT, sticky until reset
        opcode = 6'b111111;
        tick(); chk("ill_decode", dec);
        tick(); chk("ill_halt", ev(0,0,0,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,1));
        opcode = 6'b000000; mem_ready = 1'b0;
        tick(); chk("ill_halt_hold1", ev(0,0,0,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,1));
        mem_ready = 1'b1;
        tick(); chk("ill_halt_hold2", ev(0,0,0,0,0,2'b00,2'b00,0,0,2'b00,3'b000,2'b00,1));
        chk_cnt("halt_cnt0", 32'd0);
        #2 reset = 1'b1;
        #1 chk("halt_reset_idle", zero_v);
        #4 reset = 1'b0;
        tick(); chk("halt_reset_fetch", fetch_rdy);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
